// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
// Bus initiator for one CPU pipeline stage. It accepts a single-word read or
// write from the pipeline and runs the request/grant handshake. It pulses the
// address strobe for one cycle, then waits for the responder's ready. Read data
// is returned in a register. A read that times out is aborted with a one-cycle
// error pulse.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req, rw, addr,      pipeline request (level), 1 = read / 0 = write,
//   wr_data             word address and write data
//   stall, flush        pipeline stall (holds result) / flush (blocks start)
//   rd_data             registered read data
//   busy                combinational; pipeline stalls while high
//   err                 one-cycle pulse on timeout abort
//   bus_req_, bus_grnt_ bus request out / grant in, active-low
//   bus_as_             address strobe, active-low, one cycle per transaction
//   bus_rw, bus_addr,   latched transaction attributes, stable from request
//   bus_wr_data         until retirement
//   bus_rd_data         read data from the responder
//   bus_rdy_            responder ready, active-low
// -----------------------------------------------------------------------------
module bus_master_if #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

   // TIMEOUT is at most 255, so an 8-bit counter covers every legal setting.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bus_req_    <= 1'b1;
         bus_as_     <= 1'b1;
         bus_rw      <= 1'b1;
         bus_addr    <= '0;
         bus_wr_data <= '0;
         rd_data     <= '0;
         err         <= 1'b0;
         cnt         <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req && !flush) begin
                  bus_addr    <= addr;
                  bus_rw      <= rw;
                  bus_wr_data <= wr_data;
                  bus_req_    <= 1'b0;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (!bus_grnt_) begin
                  bus_as_ <= 1'b0;
                  cnt     <= '0;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               // The strobe was driven low on entry; it drops back after one cycle.
               bus_as_ <= 1'b1;
               if (!bus_rdy_) begin
                  // Ready takes priority over a timeout on the same edge.
                  if (bus_rw) begin
                     rd_data <= bus_rd_data;
                  end
                  bus_req_ <= 1'b1;
                  state    <= stall ? STALL : IDLE;
               end else if (cnt == CNT_LAST) begin
                  bus_req_ <= 1'b1;
                  rd_data  <= '0;
                  err      <= 1'b1;
                  state    <= stall ? STALL : IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            STALL: begin
               if (!stall) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A request about to be accepted already counts as busy, so the pipeline
   // stalls in the same cycle it asks.
   assign busy = ((state == IDLE) && req && !flush) || (state == REQ) || (state == ACCESS);

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
// Testbench for bus_master_if (TIMEOUT = 8). It contains a grant model with a
// programmable delay and a responder with a programmable ready latency. Each
// issued transaction pushes its expected rd_data/err onto a scoreboard. A
// monitor pops and compares when bus_req_ deasserts.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

   localparam int AW = 30;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req, rw, stall, flush;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          busy, err;
   logic          bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wr_data;
   logic [DW-1:0] bus_rd_data;

   bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr),
      .wr_data(wr_data), .stall(stall), .flush(flush), .rd_data(rd_data),
      .busy(busy), .err(err), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
      .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
   );

   always #5 clk = ~clk;

   // Grant and responder models
   int            gnt_delay = 1;   // REQ cycles until grant
   int            rdy_lat   = 1;   // cycles after the strobe cycle; 0 = never
   int            rc = 0;
   int            acnt = 0;
   logic [DW-1:0] resp_data = '0;

   always @(posedge clk) begin
      if (bus_req_) rc <= 0;
      else          rc <= rc + 1;
      if (bus_req_)           acnt <= 0;
      else if (!bus_as_)      acnt <= 1;
      else if (acnt != 0)     acnt <= acnt + 1;
   end

   assign bus_grnt_   = !(!bus_req_ && (rc >= gnt_delay - 1));
   assign bus_rdy_    = !((rdy_lat != 0) && (acnt == rdy_lat));
   assign bus_rd_data = resp_data;

   // Checking and scoreboard
   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wd;
   logic          exp_rw;
   int            stab_bad = 0;
   logic [DW-1:0] model_rd = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin : monitor
      logic prev_req;
      int   as_cnt;
      exp_t e;
      prev_req = 1'b1;
      as_cnt   = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_req = 1'b1;
            as_cnt   = 0;
         end else begin
            if (!bus_as_) as_cnt++;
            if (!bus_req_ && (bus_addr !== exp_addr || bus_wr_data !== exp_wd || bus_rw !== exp_rw))
               stab_bad++;
            if (!prev_req && bus_req_) begin
               if (sb.size() == 0) begin
                  check("sb_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("sb_rd_data", rd_data, e.d);
                  check("sb_err", err, e.e);
               end
               check("as_once", as_cnt, 1);
               check("bus_stable", stab_bad, 0);
               as_cnt   = 0;
               stab_bad = 0;
            end
            prev_req = bus_req_;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one IDLE edge; optionally record the expectation.
   task automatic issue(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] ed, input logic ee, input logic track);
      exp_t e;
      req = 1'b1; rw = r; addr = a; wr_data = wd;
      exp_addr = a; exp_wd = wd; exp_rw = r;
      if (track) begin
         e.d = ed; e.e = ee;
         sb.push_back(e);
         model_rd = ed;
      end
      step();
      req = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus_req_ && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("done_wait_expired", 0, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      reset = 1'b0; req = 1'b0; rw = 1'b1; stall = 1'b0; flush = 1'b0;
      addr = '0; wr_data = '0;
      exp_addr = '0; exp_wd = '0; exp_rw = 1'b1;
      step(); step();
      check("rst_bus_req_", bus_req_, 1);
      check("rst_bus_as_", bus_as_, 1);
      check("rst_bus_rw", bus_rw, 1);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_err", err, 0);
      reset = 1'b1;
      step();

      // Read, immediate grant, one-cycle responder
      gnt_delay = 1; rdy_lat = 1; resp_data = 32'hDEAD_BEEF;
      req = 1'b1; rw = 1'b1; addr = 30'h10;
      #1 check("t1_c0_busy", busy, 1);
      check("t1_c0_bus_req_", bus_req_, 1);
      #1 issue(1'b1, 30'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      check("t1_c1_bus_req_", bus_req_, 0);
      check("t1_c1_bus_as_", bus_as_, 1);
      check("t1_c1_busy", busy, 1);
      step();
      check("t1_c2_bus_as_", bus_as_, 0);
      check("t1_c2_busy", busy, 1);
      step();
      check("t1_c3_bus_as_", bus_as_, 1);
      check("t1_c3_busy", busy, 1);
      step();
      check("t1_c4_rd_data", rd_data, 32'hDEAD_BEEF);
      check("t1_c4_busy", busy, 0);
      check("t1_c4_bus_req_", bus_req_, 1);

      // Write, grant delayed 3 cycles
      gnt_delay = 3; resp_data = 32'h5555_AAAA;
      issue(1'b0, 30'h20, 32'h1234_5678, model_rd, 1'b0, 1'b1);
      n = 0;
      while (bus_as_ && n < 20) begin
         if (!bus_req_) n++;
         step();
      end
      check("t2_req_cycles", n, 3);
      check("t2_bus_wr_data", bus_wr_data, 32'h1234_5678);
      check("t2_bus_rw", bus_rw, 0);
      wait_done();
      check("t2_rd_unchanged", rd_data, 32'hDEAD_BEEF);
      step();

      // Stall at completion
      gnt_delay = 1; rdy_lat = 2; resp_data = 32'hCAFE_0001; stall = 1'b1;
      issue(1'b1, 30'h24, 32'h0, 32'hCAFE_0001, 1'b0, 1'b1);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         req = 1'b1;
         #1 check("t3_stall_busy", busy, 0);
         check("t3_stall_bus_req_", bus_req_, 1);
         check("t3_stall_rd_data", rd_data, 32'hCAFE_0001);
         step();
      end
      stall = 1'b0;
      #1 check("t3_last_stall_busy", busy, 0);
      step();
      check("t3_idle_busy", busy, 1);
      req = 1'b0;
      #1 check("t3_idle_noreq_busy", busy, 0);
      step();

      // Timeout with no ready
      rdy_lat = 0;
      issue(1'b1, 30'h28, 32'h0, 32'h0, 1'b1, 1'b1);
      n = 0;
      while (bus_as_ && n < 20) begin
         step();
         n++;
      end
      n = 0;
      while (!bus_req_ && n < 50) begin
         n++;
         step();
      end
      check("t4_access_cycles", n, 8);
      check("t4_err", err, 1);
      check("t4_rd_data", rd_data, 0);
      check("t4_bus_req_", bus_req_, 1);
      step();
      check("t4_err_once", err, 0);

      // Ready on exactly the timeout edge
      rdy_lat = 7; resp_data = 32'hA5A5_0007;
      issue(1'b1, 30'h2C, 32'h0, 32'hA5A5_0007, 1'b0, 1'b1);
      wait_done();
      check("t5_err", err, 0);
      check("t5_rd_data", rd_data, 32'hA5A5_0007);
      step();
      check("t5_err_after", err, 0);

      // Flush in IDLE blocks the start
      req = 1'b1; flush = 1'b1;
      #1 check("t6_flush_busy", busy, 0);
      step(); step();
      check("t6_flush_bus_req_", bus_req_, 1);
      req = 1'b0; flush = 1'b0;
      step();

      // Flush during ACCESS does not abort
      rdy_lat = 3; resp_data = 32'h0F0F_1234;
      issue(1'b1, 30'h30, 32'h0, 32'h0F0F_1234, 1'b0, 1'b1);
      n = 0;
      while (bus_as_ && n < 20) begin
         step();
         n++;
      end
      flush = 1'b1;
      wait_done();
      check("t7_flush_rd_data", rd_data, 32'h0F0F_1234);
      flush = 1'b0;
      step();

      // Reset in the middle of ACCESS
      rdy_lat = 0;
      issue(1'b1, 30'h34, 32'h0, 32'h0, 1'b0, 1'b0);
      n = 0;
      while (bus_as_ && n < 20) begin
         step();
         n++;
      end
      check("t8_pre_bus_as_", bus_as_, 0);
      reset = 1'b0;
      #1;
      check("t8_bus_req_", bus_req_, 1);
      check("t8_bus_as_", bus_as_, 1);
      check("t8_bus_rw", bus_rw, 1);
      check("t8_bus_addr", bus_addr, 0);
      check("t8_bus_wr_data", bus_wr_data, 0);
      check("t8_rd_data", rd_data, 0);
      check("t8_busy", busy, 0);
      step();
      reset = 1'b1;
      step();
      rdy_lat = 1; resp_data = 32'h0BAD_F00D;
      issue(1'b1, 30'h3C, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
      wait_done();
      step(); step();

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
